// File: rtl/hpc_branch_unit_if.sv
// hpc_branch_unit_if: core-side signals of the PC/branch unit
interface hpc_branch_unit_if #(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  logic enable;
  logic is_c;
  logic [2:0] jmp;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] target;
  logic call;
  logic ret;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0] depth;
  logic overflow;
  logic underflow;
  modport master (
    output enable, is_c, jmp, alu_out, target, call, ret,
    input pc, depth, overflow, underflow
  );
  modport slave (
    input enable, is_c, jmp, alu_out, target, call, ret,
    output pc, depth, overflow, underflow
  );
endinterface

// File: rtl/hpc_branch_unit.sv
// hpc_branch_unit: Hack PC and branch unit with stall and circular return-address stack
module hpc_branch_unit #(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic clock,
  input logic reset,
  hpc_branch_unit_if.slave bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int PW = $clog2(STACK_DEPTH);
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [PW-1:0] tp_q, tp_d, tp_inc, tp_dec;
  logic [DW-1:0] dep_q, dep_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic zr, ng, taken, full, push;
  assign zr = bus.alu_out == '0;
  assign ng = bus.alu_out[WIDTH-1];
  assign taken = bus.is_c & ((bus.jmp[2] & ng) | (bus.jmp[1] & zr) | (bus.jmp[0] & ~ng & ~zr));
  assign pc_inc = pc_q + 1'b1;
  assign full = dep_q == DW'(STACK_DEPTH);
  assign tp_inc = tp_q == PW'(STACK_DEPTH - 1) ? '0 : tp_q + 1'b1;
  assign tp_dec = tp_q == '0 ? PW'(STACK_DEPTH - 1) : tp_q - 1'b1;
  // next state: stall, then return, then taken jump/call, else increment
  always_comb begin
    pc_d = pc_q;
    dep_d = dep_q;
    tp_d = tp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push = 1'b0;
    if (bus.enable) begin
      if (bus.ret && dep_q != '0) begin
        pc_d = stk_q[tp_dec];
        dep_d = dep_q - 1'b1;
        tp_d = tp_dec;
      end else if (bus.ret) begin
        pc_d = pc_inc;
        unf_d = 1'b1;
      end else if (taken) begin
        pc_d = bus.target;
        if (bus.call) begin
          push = 1'b1;
          tp_d = tp_inc;
          ovf_d = ovf_q | full;
          dep_d = full ? dep_q : dep_q + 1'b1;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end
  // control registers; reset wins over any push or pop
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
      dep_q <= '0;
      tp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      dep_q <= dep_d;
      tp_q <= tp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // stack storage; a full push overwrites the oldest slot since the pointer wraps
  always_ff @(posedge clock) begin
    if (reset && push) stk_q[tp_q] <= pc_inc;
  end
  assign bus.pc = pc_q;
  assign bus.depth = dep_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_hpc_branch_unit.sv
// tb_hpc_branch_unit: directed scoreboard bench for hpc_branch_unit
module tb_hpc_branch_unit;
  typedef struct {
    logic [15:0] pc;
    logic [2:0] depth;
    logic ovf;
    logic unf;
  } exp_t;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic m_ovf, m_unf;
  logic [15:0] alus [3];
  hpc_branch_unit_if #(.WIDTH(16), .STACK_DEPTH(4)) bus ();
  hpc_branch_unit #(.WIDTH(16), .STACK_DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic step(input logic rst, input logic en, input logic ic, input logic [2:0] j,
                      input logic [15:0] alu, input logic [15:0] tgt, input logic c, input logic r,
                      input string tag);
    exp_t e;
    logic tk;
    @(negedge clock);
    reset = rst;
    bus.enable = en;
    bus.is_c = ic;
    bus.jmp = j;
    bus.alu_out = alu;
    bus.target = tgt;
    bus.call = c;
    bus.ret = r;
    tk = ic && ((j[2] && $signed(alu) < 0) || (j[1] && alu == 16'h0) || (j[0] && $signed(alu) > 0));
    if (!rst) begin
      m_pc = 16'h0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      if (r) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc = m_pc + 16'h1;
          m_unf = 1'b1;
        end
      end else if (tk) begin
        if (c) begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
          m_stk.push_back(m_pc + 16'h1);
        end
        m_pc = tgt;
      end else begin
        m_pc = m_pc + 16'h1;
      end
    end
    e.pc = m_pc;
    e.depth = 3'(m_stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.pc === e.pc) else begin
      errors++;
      $error("FAIL %s pc got %h exp %h", tag, bus.pc, e.pc);
    end
    checks++;
    assert (bus.depth === e.depth) else begin
      errors++;
      $error("FAIL %s depth got %0d exp %0d", tag, bus.depth, e.depth);
    end
    checks++;
    assert (bus.overflow === e.ovf) else begin
      errors++;
      $error("FAIL %s overflow got %b exp %b", tag, bus.overflow, e.ovf);
    end
    checks++;
    assert (bus.underflow === e.unf) else begin
      errors++;
      $error("FAIL %s underflow got %b exp %b", tag, bus.underflow, e.unf);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.is_c = 1'b0;
    bus.jmp = 3'b000;
    bus.alu_out = 16'h0;
    bus.target = 16'h0;
    bus.call = 1'b0;
    bus.ret = 1'b0;
    m_pc = 16'h0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    alus[0] = 16'h0001;
    alus[1] = 16'h0000;
    alus[2] = 16'h8000;
    step(0, 1, 0, 3'b000, 16'h0, 16'h0, 0, 0, "reset");
    repeat (3) step(1, 1, 0, 3'b111, 16'h0, 16'h0, 0, 0, "inc");
    for (int j = 0; j < 8; j++)
      for (int a = 0; a < 3; a++)
        step(1, 1, 1, 3'(j), alus[a], 16'h0007, 0, 0, $sformatf("jmp%0d_alu%h", j, alus[a]));
    step(1, 1, 1, 3'b111, 16'h0, 16'h0005, 0, 0, "goto5");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0100, 1, 0, "call");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "ret");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0005, 0, 0, "goto5b");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0100, 1, 0, "call_a");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0300, 1, 0, "call_b");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "ret_b");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "ret_a");
    step(1, 1, 1, 3'b000, 16'h0, 16'h0400, 1, 0, "call_not_taken");
    for (int k = 1; k <= 5; k++)
      step(1, 1, 1, 3'b111, 16'h0, 16'(k * 16), 1, 0, $sformatf("ovf_call%0d", k));
    for (int k = 1; k <= 4; k++)
      step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, $sformatf("ovf_ret%0d", k));
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "underflow");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0040, 1, 0, "pre_stall_call");
    repeat (3) step(1, 0, 1, 3'b111, 16'h0, 16'h0500, 1, 1, "stall");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "post_stall_ret");
    step(1, 1, 1, 3'b111, 16'h0, 16'hFFFF, 0, 0, "goto_ffff");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 0, "wrap_inc");
    step(1, 1, 1, 3'b111, 16'h0, 16'hFFFF, 0, 0, "goto_ffff2");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0050, 1, 0, "wrap_call");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "wrap_ret");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0060, 1, 0, "pre_rst_call");
    step(0, 1, 1, 3'b111, 16'h0, 16'h0200, 1, 0, "rst_call");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 0, "first_adv");
    step(1, 1, 1, 3'b111, 16'h0, 16'h0070, 1, 0, "pre_rst_stall");
    step(0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 1, "rst_stall");
    step(1, 1, 0, 3'b000, 16'h0, 16'h0, 0, 1, "post_rst_ret");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hpc_branch_unit.md
# hpc_branch_unit

Parametrised program-counter and branch unit for the Hack CPU family. It replaces the fixed 16-bit PC and jump logic with configurable width, a stall input, and a hardware return-address stack that provides call and return. It sits between the ALU output and the instruction-memory address bus. The CPU core drives the decoded jump bits, the ALU result and the A-register target, and the block returns the next fetch address.

## Interface
Parameters:
- WIDTH, 16, datapath and PC width in bits.
- STACK_DEPTH, 8, number of return-address entries. Must be 2 or more.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clock  in  1  single clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-low. A 0 sampled at a rising edge resets the block.
- enable  in  1  1 advances the PC this cycle; 0 stalls and holds all state.
- is_c  in  1  current instruction is a C-instruction. The jump bits are ignored when this is 0.
- jmp  in  3  Hack jump field {j1=lt, j2=eq, j3=gt}.
- alu_out  in  WIDTH  ALU result. zr and ng are derived from it internally.
- target  in  WIDTH  jump destination (A register).
- call  in  1  a taken jump also pushes the return address PC+1.
- ret  in  1  pop the top of the return stack into the PC.
- pc  out  WIDTH  registered fetch address.
- depth  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  out  1  sticky; set when a push occurs while the stack is full.
- underflow  out  1  sticky; set when a return occurs while the stack is empty.

## Operation
- Flag derivation:
  - zr = (alu_out == 0).
  - ng = alu_out[WIDTH-1].
- Jump decision: taken = is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr)).
  - jmp=000: never taken.
  - jmp=111: always taken when is_c=1.
- Per-cycle priority (first match wins):
  1. reset=0: pc=RESET_VECTOR, depth=0, overflow=0, underflow=0. Stack contents are don't-care.
  2. enable=0: hold all state. call and ret are ignored.
  3. ret=1 with depth>0: pc = top entry; depth decrements. jmp and call are ignored.
  4. ret=1 with depth=0: pc = pc+1; underflow set; depth stays 0.
  5. taken=1 with call=1: push pc+1; pc = target.
  6. taken=1 with call=0: pc = target.
  7. Otherwise: pc = pc+1. call is ignored when the jump is not taken.
- Push when depth=STACK_DEPTH:
  - The stack is circular: the oldest entry is overwritten.
  - depth stays at STACK_DEPTH.
  - overflow is set.
- Arithmetic:
  - pc+1 wraps modulo 2^WIDTH, so all-ones goes to 0.
  - The pushed return address wraps the same way.
- Stack implementation:
  - Register array indexed by a top pointer that wraps modulo STACK_DEPTH.
  - No combinational path from any input to pc.

## Timing
- pc, depth, overflow and underflow are all registers. Latency from inputs to pc is 1 clock.
- Reset values:
  - pc = RESET_VECTOR
  - depth = 0
  - overflow = 0
  - underflow = 0
- Reset asserted mid-call, mid-return or mid-stall: reset wins in that cycle. No push or pop takes effect.
- First cycle after reset deasserts: pc = RESET_VECTOR. The first advance happens on the next enabled edge.
- A push and a return in the same cycle cannot occur, because ret has priority.
- A return value pushed in cycle N is poppable in cycle N+1.
- Sticky flags clear only on reset.

## Test plan
Default configuration: WIDTH=16, STACK_DEPTH=4, RESET_VECTOR=0.
- Reset and increment: reset=0 for 1 edge, then 3 enabled edges with is_c=0 -> pc 0,1,2,3; depth=0; both flags 0.
- Jump matrix:
  - For each jmp in 000..111 and each alu_out in {0x0001, 0x0000, 0x8000}, with target=0x0007 -> pc=0x0007 exactly when the Hack condition holds, else pc+1.
  - Example: JLT with alu_out=0x8000 is taken.
  - Example: JNE with alu_out=0x0000 is not taken.
- Call and return:
  - At pc=5, call with target=0x0100 and jmp=111 -> pc=0x0100, depth=1.
  - Then ret -> pc=0x0006, depth=0.
  - Nested calls at pc 5 then 0x0100 -> returns give 0x0101, then 0x0006.
- Overflow and underflow:
  - 5 consecutive calls -> depth=4, overflow=1.
  - Then 4 returns give the last 4 return addresses.
  - A 5th return -> pc+1, underflow=1, depth=0.
- Stall and wrap:
  - enable=0 for 3 edges while ret=1 -> pc, depth and flags unchanged.
  - With pc=0xFFFF, an increment -> pc=0x0000.
  - A call at pc=0xFFFF pushes 0x0000.
- Reset mid-operation: reset=0 together with call=1, target=0x0200 -> pc=0, depth=0, flags cleared.
